// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive byte FIFO with sticky overflow; define UART_RX_FIFO_LINE_COUNT_EN to track buffered newlines
module uart_rx_fifo #(
  parameter int depth = 16,
  localparam int AW = $clog2(depth)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [AW:0] count,
  output logic        full,
  output logic        overflow,
  input  logic        clear_ovf,
  output logic [AW:0] line_count,
  output logic        line_avail
);
  logic [7:0]    mem [depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  assign full      = count == (AW+1)'(depth);
  assign out_valid = count != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;
  assign line_avail = line_count != '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count    <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      overflow <= (in_valid && full) ? 1'b1 : clear_ovf ? 1'b0 : overflow;
    end
`ifdef UART_RX_FIFO_LINE_COUNT_EN
  logic lc_inc, lc_dec;
  assign lc_inc = push && in_data == 8'h0A;
  assign lc_dec = pop && out_data == 8'h0A;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) line_count <= '0;
    else line_count <= (lc_inc && !lc_dec) ? line_count + 1'b1 : (lc_dec && !lc_inc) ? line_count - 1'b1 : line_count;
`else
  assign line_count = '0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (depth 16)
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       clear_ovf;
  logic [4:0] line_count;
  logic       line_avail;
  int errors = 0;
  int checks = 0;
  uart_rx_fifo #(.depth(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .overflow(overflow), .clear_ovf(clear_ovf),
    .line_count(line_count), .line_avail(line_avail)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
`ifdef UART_RX_FIFO_LINE_COUNT_EN
    automatic int lc_en = 1;
`else
    automatic int lc_en = 0;
`endif
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_line_count", 32'(line_count), 0);
    chk("rst_line_avail", 32'(line_avail), 0);
    rst_n = 1'b1;
    tick();
    chk("pre_push_data", 32'(out_data), 0);
    in_valid = 1'b1; in_data = 8'h48;
    tick();
    in_valid = 1'b0;
    chk("push1_valid", 32'(out_valid), 1);
    chk("push1_data", 32'(out_data), 32'h48);
    chk("push1_count", 32'(count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop1_count", 32'(count), 0);
    chk("pop1_valid", 32'(out_valid), 0);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_data = 8'hAA;
    tick();
    in_valid = 1'b0;
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_overflow", 32'(overflow), 1);
    chk("fill_line_count", 32'(line_count), lc_en ? 1 : 0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_count", 32'(count), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      chk("stream_data", 32'(out_data), 32'(i));
      chk("stream_count", 32'(count), 1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_end_count", 32'(count), 0);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("full2", 32'(full), 1);
    in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1; clear_ovf = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
    chk("combo_overflow", 32'(overflow), 1);
    chk("combo_count", 32'(count), 15);
    chk("combo_head", 32'(out_data), 32'h11);
    clear_ovf = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("combo_drain", 32'(out_data), 32'(8'h10 + i));
      tick();
      clear_ovf = 1'b0;
    end
    out_ready = 1'b0;
    chk("combo_empty", 32'(count), 0);
    chk("combo_ovf_clr", 32'(overflow), 0);
    in_valid = 1'b1;
    in_data = 8'h68; tick();
    in_data = 8'h69; tick();
    in_data = 8'h0A; tick();
    in_data = 8'h0A; tick();
    in_valid = 1'b0;
    chk("line_cnt2", 32'(line_count), lc_en ? 2 : 0);
    chk("line_avail2", 32'(line_avail), lc_en ? 1 : 0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("line_cnt1", 32'(line_count), lc_en ? 1 : 0);
    tick();
    out_ready = 1'b0;
    chk("line_cnt0", 32'(line_count), 0);
    chk("line_avail0", 32'(line_avail), 0);
    chk("line_empty", 32'(count), 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h31 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_overflow", 32'(overflow), 0);
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_strobe_lost", 32'(count), 0);
    in_valid = 1'b1; in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    chk("post_rst_data", 32'(out_data), 32'h99);
    chk("post_rst_count", 32'(count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_empty", 32'(out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
